// File: rtl/imm_gen_pipe_if.sv
// Decode-side handshake bundle for imm_gen_pipe: instruction request in, immediate result out.
// master = instruction producer / result consumer, slave = the generator.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Elastic RV32/RV64 immediate generator: combinational decode feeding STAGES
// valid/ready register stages, plus a saturating count of illegal encodings.
module imm_gen_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 1,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_gen_pipe_if.slave    bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
    $error("imm_gen_pipe: STAGES must be 1 or 2");
  end

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U    = 3'd4, FMT_J = 3'd5, FMT_SH = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } res_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        is_sh;
  res_t        dec;

  assign instr = bus.in_instr;
  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign is_sh = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec         = '0;
    dec.tag     = bus.in_tag;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (op)
      OP_LOAD, OP_JALR: begin
        dec.imm = XLEN'($signed(instr[31:20]));
        dec.fmt = FMT_I;
      end
      OP_IMM: begin
        if (is_sh) begin
          dec.fmt = FMT_SH;
          // RV32 has only 5 shamt bits; shamt[5] set is an illegal encoding
          if (XLEN == 64) begin
            dec.imm = XLEN'(instr[25:20]);
          end else begin
            dec.imm     = XLEN'(instr[24:20]);
            dec.illegal = instr[25];
          end
        end else begin
          dec.imm = XLEN'($signed(instr[31:20]));
          dec.fmt = FMT_I;
        end
      end
      OP_IMM32: begin
        if (XLEN == 32) begin
          dec.illegal = 1'b1;
        end else if (is_sh) begin
          dec.imm = XLEN'(instr[24:20]);
          dec.fmt = FMT_SH;
        end else begin
          dec.imm = XLEN'($signed(instr[31:20]));
          dec.fmt = FMT_I;
        end
      end
      OP_STORE: begin
        dec.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
        dec.fmt = FMT_S;
      end
      OP_BRANCH: begin
        dec.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        dec.fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec.imm = XLEN'($signed({instr[31:12], 12'b0}));
        dec.fmt = FMT_U;
      end
      OP_JAL: begin
        dec.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        dec.fmt = FMT_J;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Elastic pipeline: stage k loads when it is empty or its contents move on.
  logic [STAGES-1:0] vld_pipe;
  res_t              stg     [STAGES];
  res_t              src     [STAGES];
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] go;
  logic              all_full;

  always_comb begin
    src[0]     = dec;
    src_vld[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src[k]     = stg[k-1];
      src_vld[k] = vld_pipe[k-1];
    end
  end

  // Stage k can load iff the consumer takes the head or any stage from k on is empty.
  always_comb begin
    all_full = 1'b1;
    go       = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & vld_pipe[k];
      go[k]    = bus.out_ready | !all_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 0; k < STAGES; k++) stg[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (go[k]) begin
          vld_pipe[k] <= src_vld[k];
          if (src_vld[k]) stg[k] <= src[k];
        end
      end
    end
  end

  assign bus.in_ready    = go[0];
  assign bus.out_valid   = vld_pipe[STAGES-1];
  assign bus.out_imm     = stg[STAGES-1].imm;
  assign bus.out_fmt     = stg[STAGES-1].fmt;
  assign bus.out_illegal = stg[STAGES-1].illegal;
  assign bus.out_tag     = stg[STAGES-1].tag;

  logic acc_illegal;
  assign acc_illegal = bus.in_valid & go[0] & dec.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (clr_cnt) begin
      illegal_cnt <= '0;
    end else if (acc_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: RV64/2-stage main instance, a 2-bit counter
// instance for saturation, and an RV32/1-stage instance for the 32-bit decode rules.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr_m = 1'b0, clr_s = 1'b0, clr_w = 1'b0;
  logic [15:0] cnt_m, cnt_w;
  logic [1:0]  cnt_s;

  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) m_if ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) s_if ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) w_if ();

  imm_gen_pipe #(.XLEN(64), .STAGES(2), .TAG_W(8), .CNT_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(m_if), .clr_cnt(clr_m), .illegal_cnt(cnt_m));
  imm_gen_pipe #(.XLEN(64), .STAGES(2), .TAG_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(s_if), .clr_cnt(clr_s), .illegal_cnt(cnt_s));
  imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(8), .CNT_W(16)) u_x32 (
    .clk(clk), .rst_n(rst_n), .bus(w_if), .clr_cnt(clr_w), .illegal_cnt(cnt_w));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] v_ins [6] = '{32'hFFF00093, 32'hFE113C23, 32'hFE000EE3,
                             32'h800000B7, 32'h0010006F, 32'h43F0D093};
  logic [63:0] v_imm [6] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
                             64'hFFFFFFFF80000000, 64'h0000000000000800, 64'd63};
  logic [2:0]  v_fmt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

  logic [31:0] w_ins [4] = '{32'h02009093, 32'h0000009B, 32'h800000B7, 32'h01F09093};
  logic [31:0] w_imm [4] = '{32'h0, 32'h0, 32'h80000000, 32'd31};
  logic [2:0]  w_fmt [4] = '{3'd6, 3'd0, 3'd4, 3'd6};
  logic        w_ill [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m_if.in_valid = 0; m_if.in_instr = '0; m_if.in_tag = '0; m_if.out_ready = 0;
    s_if.in_valid = 0; s_if.in_instr = '0; s_if.in_tag = '0; s_if.out_ready = 1;
    w_if.in_valid = 0; w_if.in_instr = '0; w_if.in_tag = '0; w_if.out_ready = 1;

    // reset state
    tick; tick;
    check("rst_out_valid", m_if.out_valid, 0);
    check("rst_out_imm", m_if.out_imm, 0);
    check("rst_cnt", cnt_m, 0);
    check("rst_w_valid", w_if.out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", m_if.in_ready, 1);

    // 1: back-to-back decode, 2-cycle latency
    for (int i = 0; i < 8; i++) begin
      m_if.out_ready = 1;
      m_if.in_valid  = (i < 6);
      m_if.in_tag    = 8'(i + 1);
      if (i < 6) m_if.in_instr = v_ins[i];
      #1;
      check("t1_in_ready", m_if.in_ready, 1);
      if (i >= 2) begin
        check("t1_valid", m_if.out_valid, 1);
        check("t1_imm", m_if.out_imm, v_imm[i-2]);
        check("t1_fmt", m_if.out_fmt, v_fmt[i-2]);
        check("t1_illegal", m_if.out_illegal, 0);
        check("t1_tag", m_if.out_tag, 64'(i - 1));
      end else begin
        check("t1_latency", m_if.out_valid, 0);
      end
      tick;
    end
    m_if.in_valid = 0;
    #1;
    check("t1_drained", m_if.out_valid, 0);

    // 2: backpressure, stall then release
    m_if.out_ready = 0;
    m_if.in_valid = 1; m_if.in_instr = 32'h00500093; m_if.in_tag = 8'h11;
    #1; check("t2_acc_a", m_if.in_ready, 1);
    tick;
    m_if.in_instr = 32'h00A00093; m_if.in_tag = 8'h12;
    #1; check("t2_acc_b", m_if.in_ready, 1);
    check("t2_not_yet", m_if.out_valid, 0);
    tick;
    m_if.in_instr = 32'h80000037; m_if.in_tag = 8'h13;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t2_full", m_if.in_ready, 0);
      check("t2_hold_valid", m_if.out_valid, 1);
      check("t2_hold_tag", m_if.out_tag, 8'h11);
      check("t2_hold_imm", m_if.out_imm, 64'd5);
      tick;
    end
    m_if.out_ready = 1;
    #1;
    check("t2_release_ready", m_if.in_ready, 1);
    check("t2_a_tag", m_if.out_tag, 8'h11);
    tick;
    m_if.in_valid = 0;
    #1;
    check("t2_b_valid", m_if.out_valid, 1);
    check("t2_b_tag", m_if.out_tag, 8'h12);
    check("t2_b_imm", m_if.out_imm, 64'd10);
    tick;
    check("t2_c_valid", m_if.out_valid, 1);
    check("t2_c_tag", m_if.out_tag, 8'h13);
    check("t2_c_imm", m_if.out_imm, 64'hFFFFFFFF80000000);
    check("t2_c_fmt", m_if.out_fmt, 3'd4);
    tick;
    check("t2_drained", m_if.out_valid, 0);

    // 3: illegal opcode, counting and saturation
    for (int i = 0; i < 8; i++) begin
      m_if.in_valid = (i < 3); m_if.in_instr = 32'h0000007F; m_if.in_tag = 8'(8'h40 + i);
      s_if.in_valid = (i < 5); s_if.in_instr = 32'h0000007F; s_if.in_tag = 8'(i);
      #1;
      if (i >= 2 && i < 5) begin
        check("t3_valid", m_if.out_valid, 1);
        check("t3_illegal", m_if.out_illegal, 1);
        check("t3_fmt", m_if.out_fmt, 3'd0);
        check("t3_imm", m_if.out_imm, 64'd0);
      end
      if (i == 3) check("t3_sat_at3", cnt_s, 2'd3);
      if (i == 5) check("t3_sat_at5", cnt_s, 2'd3);
      tick;
    end
    m_if.in_valid = 0; s_if.in_valid = 0;
    #1;
    check("t3_cnt", cnt_m, 16'd3);
    check("t3_sat_final", cnt_s, 2'd3);

    // 4: clear wins over a same-cycle illegal accept
    m_if.in_valid = 1; m_if.in_instr = 32'h0000007F; clr_m = 1;
    tick;
    m_if.in_valid = 0; clr_m = 0;
    #1; check("t4_clr", cnt_m, 16'd0);
    m_if.in_valid = 1;
    tick;
    m_if.in_valid = 0;
    #1; check("t4_inc", cnt_m, 16'd1);
    tick; tick; tick;

    // 5: RV32 decode rules, 1-stage instance
    for (int i = 0; i < 5; i++) begin
      w_if.in_valid = (i < 4); w_if.in_tag = 8'(i);
      if (i < 4) w_if.in_instr = w_ins[i];
      #1;
      if (i >= 1) begin
        check("t5_valid", w_if.out_valid, 1);
        check("t5_illegal", w_if.out_illegal, w_ill[i-1]);
        check("t5_imm", w_if.out_imm, w_imm[i-1]);
        check("t5_fmt", w_if.out_fmt, w_fmt[i-1]);
      end
      tick;
    end
    w_if.in_valid = 0;
    #1;
    check("t5_cnt", cnt_w, 16'd2);

    // 6: async reset with results in flight
    m_if.out_ready = 0;
    m_if.in_valid = 1; m_if.in_instr = 32'h00300093; m_if.in_tag = 8'h21;
    tick;
    m_if.in_tag = 8'h22;
    tick;
    m_if.in_valid = 0;
    #1;
    check("t6_inflight", m_if.out_valid, 1);
    rst_n = 0;
    #1;
    check("t6_rst_valid", m_if.out_valid, 0);
    check("t6_rst_cnt", cnt_m, 16'd0);
    check("t6_rst_tag", m_if.out_tag, 8'h00);
    tick;
    rst_n = 1;
    #1;
    check("t6_rel_ready", m_if.in_ready, 1);
    m_if.in_valid = 1; m_if.in_instr = 32'h00100093; m_if.in_tag = 8'h33; m_if.out_ready = 1;
    tick;
    m_if.in_valid = 0;
    #1;
    check("t6_lat1", m_if.out_valid, 0);
    tick;
    check("t6_valid", m_if.out_valid, 1);
    check("t6_tag", m_if.out_tag, 8'h33);
    check("t6_imm", m_if.out_imm, 64'd1);
    tick;
    check("t6_no_dup", m_if.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
